// File: rtl/fetch_ctrl_pkg.sv
// Shared command codes, controller state encoding and word-geometry helper
// for the instruction-fetch run controller.
package fetch_ctrl_pkg;

   localparam logic [7:0] CMD_LOAD    = 8'h4C;
   localparam logic [7:0] CMD_CONT    = 8'h43;
   localparam logic [7:0] CMD_STEP    = 8'h53;
   localparam logic [7:0] CMD_RESTART = 8'h52;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD_CNT  = 3'd1,
      ST_LOAD_DATA = 3'd2,
      ST_RUN       = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   function automatic int bytes_per_word(input int nbits);
      return nbits / 8;
   endfunction

   localparam int NBITS_DEFAULT  = 32;
   localparam int BYTES_PER_WORD = bytes_per_word(NBITS_DEFAULT);

endpackage

// File: rtl/byte_word_assembler.sv
// Packs a byte stream MSB-first into NBITS words; word_vld_o flags the byte
// that completes a word, with word_o already holding the full word.
module byte_word_assembler
   import fetch_ctrl_pkg::*;
#(
   parameter int NBITS = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic [7:0]       byte_i,
   input  logic             byte_vld_i,
   output logic [NBITS-1:0] word_o,
   output logic             word_vld_o
);

   localparam int BPW = bytes_per_word(NBITS);

   logic [NBITS-1:0] acc_q, acc_d;
   logic [7:0]       idx_q, idx_d;

   // Older bytes shift out of the top, so a stale previous word never leaks.
   always_comb begin
      word_o     = (acc_q << 8) | NBITS'(byte_i);
      word_vld_o = byte_vld_i && (idx_q == 8'(BPW - 1));
      acc_d      = acc_q;
      idx_d      = idx_q;
      if (clr_i) begin
         acc_d = '0;
         idx_d = '0;
      end else if (byte_vld_i) begin
         acc_d = word_o;
         idx_d = word_vld_o ? 8'd0 : idx_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q <= '0;
         idx_q <= '0;
      end else begin
         acc_q <= acc_d;
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/fetch_run_ctrl.sv
// Debug-link controller for the fetch stage: loads program words into
// instruction memory and releases the pipeline in run or single-step mode.
module fetch_run_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int NBITS  = 32,
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   output logic              o_rx_ready,
   input  logic              i_halt_signal,
   output logic              o_pipe_enable,
   output logic              o_pc_reset,
   output logic              o_imem_we,
   output logic [ADDR_W-1:0] o_imem_waddr,
   output logic [NBITS-1:0]  o_imem_wdata,
   output logic              o_busy,
   output logic              o_done,
   output logic [2:0]        o_state,
   output logic [CNT_W-1:0]  o_cycle_count
);

   state_t            state_q, state_d;
   logic              rx_ready_q, rx_ready_d;
   logic              pipe_en_q, pipe_en_d;
   logic              pc_reset_q, pc_reset_d;
   logic              imem_we_q, imem_we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [NBITS-1:0]  wdata_q, wdata_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        words_q, words_d;

   logic              consume;
   logic              step_halt;
   logic              load_cmd;
   logic              asm_byte_vld;
   logic              asm_word_vld;
   logic [NBITS-1:0]  asm_word;

   assign consume   = i_rx_valid && rx_ready_q;
   assign step_halt = pipe_en_q && i_halt_signal;
   // A halt seen during a single step outranks a byte arriving in the same cycle.
   assign load_cmd  = consume && (i_rx_data == CMD_LOAD) &&
                      (((state_q == ST_IDLE) && !step_halt) || (state_q == ST_DONE));
   assign asm_byte_vld = consume && (state_q == ST_LOAD_DATA) && (words_q != 8'd0);

   byte_word_assembler #(
      .NBITS (NBITS)
   ) u_asm (
      .clk_i      (i_clk),
      .rst_ni     (i_reset),
      .clr_i      (load_cmd),
      .byte_i     (i_rx_data),
      .byte_vld_i (asm_byte_vld),
      .word_o     (asm_word),
      .word_vld_o (asm_word_vld)
   );

   always_comb begin
      state_d    = state_q;
      pipe_en_d  = 1'b0;
      pc_reset_d = 1'b0;
      imem_we_d  = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      words_d    = words_q;
      cnt_d      = cnt_q;

      if (pipe_en_q && (cnt_q != '1))
         cnt_d = cnt_q + CNT_W'(1);
      // Address advances once the strobe cycle has shown the current one.
      if (imem_we_q)
         waddr_d = waddr_q + ADDR_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (step_halt) begin
               state_d = ST_DONE;
            end else if (consume) begin
               case (i_rx_data)
                  CMD_LOAD: begin
                     state_d = ST_LOAD_CNT;
                     waddr_d = '0;
                  end
                  CMD_CONT: begin
                     state_d   = ST_RUN;
                     pipe_en_d = 1'b1;
                  end
                  CMD_STEP: pipe_en_d = 1'b1;
                  default: ;
               endcase
            end
         end
         ST_LOAD_CNT: begin
            if (consume) begin
               if (i_rx_data == 8'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  words_d = i_rx_data;
                  state_d = ST_LOAD_DATA;
               end
            end
         end
         ST_LOAD_DATA: begin
            if (asm_word_vld) begin
               imem_we_d = 1'b1;
               wdata_d   = asm_word;
               words_d   = words_q - 8'd1;
            end
            if (imem_we_q && (words_q == 8'd0)) begin
               state_d    = ST_IDLE;
               pc_reset_d = 1'b1;
               cnt_d      = '0;
            end
         end
         ST_RUN: begin
            if (step_halt)
               state_d = ST_DONE;
            else
               pipe_en_d = 1'b1;
         end
         ST_DONE: begin
            if (consume) begin
               if (i_rx_data == CMD_RESTART) begin
                  state_d    = ST_IDLE;
                  pc_reset_d = 1'b1;
                  cnt_d      = '0;
               end else if (i_rx_data == CMD_LOAD) begin
                  state_d = ST_LOAD_CNT;
                  waddr_d = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d     = state_d inside {ST_LOAD_CNT, ST_LOAD_DATA, ST_RUN};
      done_d     = (state_d == ST_DONE);
      rx_ready_d = (state_d != ST_RUN);
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= ST_IDLE;
         rx_ready_q <= 1'b1;
         pipe_en_q  <= 1'b0;
         pc_reset_q <= 1'b0;
         imem_we_q  <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         cnt_q      <= '0;
         words_q    <= '0;
      end else begin
         state_q    <= state_d;
         rx_ready_q <= rx_ready_d;
         pipe_en_q  <= pipe_en_d;
         pc_reset_q <= pc_reset_d;
         imem_we_q  <= imem_we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         cnt_q      <= cnt_d;
         words_q    <= words_d;
      end
   end

   assign o_rx_ready    = rx_ready_q;
   assign o_pipe_enable = pipe_en_q;
   assign o_pc_reset    = pc_reset_q;
   assign o_imem_we     = imem_we_q;
   assign o_imem_waddr  = waddr_q;
   assign o_imem_wdata  = wdata_q;
   assign o_busy        = busy_q;
   assign o_done        = done_q;
   assign o_state       = state_q;
   assign o_cycle_count = cnt_q;

endmodule

// File: tb/tb_fetch_run_ctrl.sv
// Self-checking bench for fetch_run_ctrl: command table, hand-written
// multi-cycle sequences and randomized load/step/run rounds.
module tb_fetch_run_ctrl;

   localparam int NBITS  = 32;
   localparam int ADDR_W = 8;
   localparam int CNT_W  = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_valid = 1'b0;
   logic              halt = 1'b0;
   logic              rx_ready, pipe_enable, pc_reset, imem_we, busy, done;
   logic [ADDR_W-1:0] imem_waddr;
   logic [NBITS-1:0]  imem_wdata;
   logic [2:0]        state;
   logic [CNT_W-1:0]  cycle_count;

   fetch_run_ctrl #(.NBITS(NBITS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .i_clk         (clk),
      .i_reset       (rst_n),
      .i_rx_data     (rx_data),
      .i_rx_valid    (rx_valid),
      .o_rx_ready    (rx_ready),
      .i_halt_signal (halt),
      .o_pipe_enable (pipe_enable),
      .o_pc_reset    (pc_reset),
      .o_imem_we     (imem_we),
      .o_imem_waddr  (imem_waddr),
      .o_imem_wdata  (imem_wdata),
      .o_busy        (busy),
      .o_done        (done),
      .o_state       (state),
      .o_cycle_count (cycle_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Monitor: the only writer of these observation counters and logs.
   int cyc = 0, en_cnt = 0, en_rise = 0, pcr_cnt = 0, pcr_last = 0, we_last = 0, viol = 0;
   logic en_prev = 1'b0;
   logic [ADDR_W-1:0] we_addr[$];
   logic [NBITS-1:0]  we_data[$];

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (pipe_enable) en_cnt = en_cnt + 1;
      if (pipe_enable && !en_prev) en_rise = en_rise + 1;
      en_prev = pipe_enable;
      if (pc_reset) begin
         pcr_cnt  = pcr_cnt + 1;
         pcr_last = cyc;
      end
      if (imem_we && rst_n) begin
         we_addr.push_back(imem_waddr);
         we_data.push_back(imem_wdata);
         we_last = cyc;
      end
      if (state == 3'd3 && (rx_ready || !busy)) viol = viol + 1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      t = 0;
      while (!rx_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!rx_ready) chk("rx_ready_wait", 64'(rx_ready), 64'd1);
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic send_gap(input logic [7:0] b);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(b);
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   // Start a continuous run and raise halt during the k-th enabled cycle.
   task automatic run_until_halt(input int k);
      int seen;
      seen = 0;
      send_byte(8'h43);
      for (int t = 0; t < 200 && seen < k; t++) begin
         @(negedge clk);
         if (pipe_enable) begin
            seen++;
            if (seen == k) halt = 1'b1;
         end
      end
      if (seen < k) chk("run_enable_wait", 64'(seen), 64'(k));
      @(posedge clk);
      #1 halt = 1'b0;
   endtask

   typedef struct {
      logic [7:0] b;
      logic       hlt;
      logic [2:0] st;
      logic       dn;
      int         en;
      int         pcr;
      int         cnt;
   } vec_t;

   vec_t vt[7];

   initial begin
      int b_en, b_rise, b_pcr, b_we, b_viol, m_cnt, n, k;
      logic [NBITS-1:0] words[$];
      logic [NBITS-1:0] w;

      vt[0] = '{8'h7F, 1'b0, 3'd0, 1'b0, 0, 0, 0};
      vt[1] = '{8'h53, 1'b0, 3'd0, 1'b0, 1, 0, 1};
      vt[2] = '{8'h53, 1'b0, 3'd0, 1'b0, 1, 0, 2};
      vt[3] = '{8'h53, 1'b0, 3'd0, 1'b0, 1, 0, 3};
      vt[4] = '{8'h53, 1'b1, 3'd4, 1'b1, 1, 0, 4};
      vt[5] = '{8'h43, 1'b0, 3'd4, 1'b1, 0, 0, 4};
      vt[6] = '{8'h52, 1'b0, 3'd0, 1'b0, 0, 1, 0};

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_ready", 64'(rx_ready), 64'd1);
      chk("rst_en", 64'(pipe_enable), 64'd0);
      chk("rst_we", 64'(imem_we), 64'd0);
      chk("rst_pcr", 64'(pc_reset), 64'd0);
      chk("rst_busy_done", 64'({busy, done}), 64'd0);
      chk("rst_cnt", 64'(cycle_count), 64'd0);
      chk("rst_addr_data", 64'({imem_waddr, imem_wdata}), 64'd0);
      rst_n = 1'b1;
      settle(1);
      chk("idle_state", 64'(state), 64'd0);

      // Two-word load
      b_we = we_addr.size(); b_pcr = pcr_cnt;
      send_byte(8'h4C);
      chk("load_busy", 64'(busy), 64'd1);
      foreach (vt[i]) begin end
      send_byte(8'h02);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h11);
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      settle(3);
      chk("load2_nwrites", 64'(we_addr.size() - b_we), 64'd2);
      if (we_addr.size() - b_we == 2) begin
         chk("load2_addr0", 64'(we_addr[b_we]), 64'd0);
         chk("load2_data0", 64'(we_data[b_we]), 64'h0000_0011);
         chk("load2_addr1", 64'(we_addr[b_we+1]), 64'd1);
         chk("load2_data1", 64'(we_data[b_we+1]), 64'hAABB_CCDD);
      end
      chk("load2_pcr", 64'(pcr_cnt - b_pcr), 64'd1);
      chk("load2_pcr_after_we", 64'(pcr_last - we_last), 64'd1);
      chk("load2_state", 64'(state), 64'd0);

      // Zero-word load
      b_we = we_addr.size(); b_pcr = pcr_cnt;
      send_byte(8'h4C);
      send_byte(8'h00);
      settle(3);
      chk("load0_nwrites", 64'(we_addr.size() - b_we), 64'd0);
      chk("load0_pcr", 64'(pcr_cnt - b_pcr), 64'd0);
      chk("load0_state", 64'(state), 64'd0);

      // Command table: steps, halt on step, ignored bytes, restart
      for (int i = 0; i < 7; i++) begin
         b_en = en_cnt; b_rise = en_rise; b_pcr = pcr_cnt;
         halt = vt[i].hlt;
         send_byte(vt[i].b);
         repeat (4) @(negedge clk);
         halt = 1'b0;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_state", i), 64'(state), 64'(vt[i].st));
         chk($sformatf("vec%0d_done", i), 64'(done), 64'(vt[i].dn));
         chk($sformatf("vec%0d_en", i), 64'(en_cnt - b_en), 64'(vt[i].en));
         chk($sformatf("vec%0d_rise", i), 64'(en_rise - b_rise), 64'(vt[i].en));
         chk($sformatf("vec%0d_pcr", i), 64'(pcr_cnt - b_pcr), 64'(vt[i].pcr));
         chk($sformatf("vec%0d_cnt", i), 64'(cycle_count), 64'(vt[i].cnt));
         chk($sformatf("vec%0d_ready", i), 64'(rx_ready), 64'd1);
      end

      // Continuous run halted on the 6th enabled cycle
      b_en = en_cnt; b_viol = viol;
      run_until_halt(6);
      settle(2);
      chk("run6_en", 64'(en_cnt - b_en), 64'd6);
      chk("run6_cnt", 64'(cycle_count), 64'd6);
      chk("run6_done", 64'(done), 64'd1);
      chk("run6_state", 64'(state), 64'd4);
      chk("run6_ready_busy", 64'(viol - b_viol), 64'd0);
      send_byte(8'h52);
      settle(1);
      chk("run6_restart_cnt", 64'(cycle_count), 64'd0);

      // Reset asserted mid-run takes effect without a clock edge
      send_byte(8'h43);
      repeat (3) @(negedge clk);
      chk("midrun_en", 64'(pipe_enable), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_state", 64'(state), 64'd0);
      chk("arst_en", 64'(pipe_enable), 64'd0);
      chk("arst_ready", 64'(rx_ready), 64'd1);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_cnt", 64'(cycle_count), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      settle(1);
      chk("arst_after_state", 64'(state), 64'd0);
      m_cnt = 0;

      // Randomized rounds against the reference model
      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(1, 5);
         words.delete();
         for (int j = 0; j < n; j++) words.push_back(NBITS'($urandom));
         b_we = we_addr.size(); b_pcr = pcr_cnt;
         send_gap(8'h4C);
         send_gap(8'(n));
         foreach (words[j]) begin
            w = words[j];
            for (int q = NBITS / 8 - 1; q >= 0; q--) begin
               halt = 1'($urandom_range(0, 1));
               send_gap(w[q*8 +: 8]);
            end
         end
         halt = 1'b0;
         settle(3);
         m_cnt = 0;
         chk($sformatf("r%0d_nwrites", r), 64'(we_addr.size() - b_we), 64'(n));
         if (we_addr.size() - b_we == n) begin
            for (int j = 0; j < n; j++) begin
               chk($sformatf("r%0d_addr%0d", r, j), 64'(we_addr[b_we+j]), 64'(j));
               chk($sformatf("r%0d_data%0d", r, j), 64'(we_data[b_we+j]), 64'(words[j]));
            end
         end
         chk($sformatf("r%0d_load_pcr", r), 64'(pcr_cnt - b_pcr), 64'd1);
         chk($sformatf("r%0d_load_cnt", r), 64'(cycle_count), 64'(m_cnt));

         k = $urandom_range(1, 3);
         b_en = en_cnt;
         for (int j = 0; j < k; j++) begin
            send_gap(8'h53);
            repeat (2) @(negedge clk);
         end
         settle(1);
         m_cnt += k;
         chk($sformatf("r%0d_step_en", r), 64'(en_cnt - b_en), 64'(k));
         chk($sformatf("r%0d_step_cnt", r), 64'(cycle_count), 64'(m_cnt));
         chk($sformatf("r%0d_step_state", r), 64'(state), 64'd0);

         k = $urandom_range(1, 12);
         b_en = en_cnt;
         run_until_halt(k);
         settle(2);
         m_cnt += k;
         chk($sformatf("r%0d_run_en", r), 64'(en_cnt - b_en), 64'(k));
         chk($sformatf("r%0d_run_cnt", r), 64'(cycle_count), 64'(m_cnt));
         chk($sformatf("r%0d_run_done", r), 64'({state, done}), 64'({3'd4, 1'b1}));

         b_pcr = pcr_cnt;
         send_gap(8'h52);
         settle(1);
         m_cnt = 0;
         chk($sformatf("r%0d_rst_pcr", r), 64'(pcr_cnt - b_pcr), 64'd1);
         chk($sformatf("r%0d_rst_cnt", r), 64'(cycle_count), 64'(m_cnt));
         chk($sformatf("r%0d_rst_state", r), 64'(state), 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fetch_run_ctrl.md
Name: fetch_run_ctrl

Overview:
- Sequences the instruction-fetch datapath: PC, PC adder, jump mux and instruction memory.
- Receives a byte command stream from the debug link and loads program words into instruction memory.
- Releases the pipeline in continuous or single-step mode, and stops it when the fetch stage flags a HALT instruction.
- Sits between the debug receiver and the fetch stage's enable and instruction-memory write ports.

Parameters:
- NBITS, 32, instruction/data word width (multiple of 8).
- ADDR_W, 8, instruction memory word-address width.
- CNT_W, 32, cycle counter width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_rx_data  in  8  command/data byte.
- i_rx_valid  in  1  i_rx_data valid.
- o_rx_ready  out  1  controller can accept a byte.
- i_halt_signal  in  1  HALT detected by fetch (fetch stage o_halt_signal).
- o_pipe_enable  out  1  pipeline/fetch enable.
- o_pc_reset  out  1  one-cycle synchronous restart pulse to PC/pipeline.
- o_imem_we  out  1  instruction memory write strobe.
- o_imem_waddr  out  ADDR_W  write word address.
- o_imem_wdata  out  NBITS  write data.
- o_busy  out  1  high in LOAD_CNT, LOAD_DATA, RUN.
- o_done  out  1  high in DONE.
- o_state  out  3  current state encoding.
- o_cycle_count  out  CNT_W  enabled cycles since last restart.

Behaviour:
- Reset (i_reset=0, asynchronous): state IDLE; all outputs 0 except o_rx_ready=1; address, byte index and counter cleared.
- Reset asserted mid-load or mid-run aborts immediately; no write strobe occurs while reset is asserted.
- Byte handshake: a byte is consumed on the rising edge where i_rx_valid && o_rx_ready.
- o_rx_ready is 1 in IDLE, LOAD_CNT, LOAD_DATA and DONE; it is 0 in RUN.
- States: IDLE=0, LOAD_CNT=1, LOAD_DATA=2, RUN=3, DONE=4.
- IDLE, consumed 0x4C 'L' -> LOAD_CNT; write address cleared to 0.
- IDLE, consumed 0x43 'C' -> RUN.
- IDLE, consumed 0x53 'S' -> o_pipe_enable high for exactly one cycle (the next cycle). Controller stays in IDLE unless halt is seen in that cycle.
- IDLE, any other byte: consumed and ignored.
- LOAD_CNT: the consumed byte N is the word count. N=0 -> IDLE with no writes and no o_pc_reset. Otherwise -> LOAD_DATA.
- LOAD_DATA: bytes are assembled MSB-first, NBITS/8 bytes per word.
- On the consuming edge of a word's last byte, o_imem_we is high for the following cycle, with o_imem_waddr and o_imem_wdata stable during that cycle. The address then increments and wraps modulo 2^ADDR_W.
- After N words the controller returns to IDLE and pulses o_pc_reset in the cycle after the last write strobe. The cycle counter clears.
- RUN: o_pipe_enable=1 every cycle. o_cycle_count increments each enabled cycle and saturates at all-ones.
- Halt detection: i_halt_signal is sampled only in cycles where o_pipe_enable=1.
  - If sampled high, o_pipe_enable is 0 from the next cycle and the state becomes DONE.
  - The halt cycle itself is counted.
  - In single-step, a sampled halt also moves IDLE -> DONE.
- i_halt_signal is ignored while o_pipe_enable=0.
- DONE: o_done=1 and o_pipe_enable=0.
  - Consumed 0x52 'R' -> o_pc_reset pulse for one cycle, counter cleared, state IDLE.
  - Consumed 'L' -> LOAD_CNT.
  - Other bytes are consumed and ignored.
- No outputs change combinationally from inputs; every output is registered.

Decomposition:
- Shared package fetch_ctrl_pkg holds:
  - command codes CMD_LOAD=0x4C, CMD_CONT=0x43, CMD_STEP=0x53, CMD_RESTART=0x52;
  - state encodings;
  - BYTES_PER_WORD = NBITS/8.
- One sub-module, byte_word_assembler: shifts bytes MSB-first and emits a word-valid pulse on the last byte. It is reset by the same asynchronous active-low reset and also cleared on entry to LOAD_CNT.

Test Plan:
- Reset checks: with no stimulus, outputs match reset values and o_state=0.
- Assert reset mid-RUN -> all outputs return to reset values asynchronously.
- Load two words: send 4C 02 00 00 00 11 AA BB CC DD.
  - Strobe 1: o_imem_waddr=0, o_imem_wdata=0x00000011.
  - Strobe 2: o_imem_waddr=1, o_imem_wdata=0xAABBCCDD.
  - o_pc_reset pulses once, then state returns to IDLE.
- Load with N=0: send 4C 00 -> no o_imem_we, no o_pc_reset, state IDLE.
- Continuous run: send 43, then raise i_halt_signal on the 6th enabled cycle.
  - o_pipe_enable is high for exactly 6 cycles; o_cycle_count=6; o_done=1.
  - o_rx_ready=0 throughout RUN.
- Single step: send 53 three times with halt low -> three isolated one-cycle enable pulses, o_cycle_count=3, state IDLE.
  - A 4th step with halt high -> DONE.
  - Then send 52 -> o_pc_reset pulses, counter=0, state IDLE.
- Unknown bytes: send 7F in IDLE and 43 in DONE -> each byte is consumed and ignored, with no enable pulse and no state change.
